// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
  localparam int          INSTR_BYTES  = 4;

endpackage

// File: rtl/fetch_next_pc.sv
// Next program counter selection: hold, sequential +4, or word-aligned redirect.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            load,
  input  logic            is_ebreak,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc
);

  // A redirect always wins; a captured EBREAK leaves the PC parked on itself.
  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
    end else if (load && !is_ebreak) begin
      next_pc = pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// hands each instruction to decode through a registered valid/ready slot.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int            XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic            load;
  logic            is_ebreak;

  assign is_ebreak = (imem_data == EBREAK_INSTR);

  // The output slot can take a new word when empty or when decode drains it.
  assign load = (state_q == FETCH) && !redirect_valid && (!id_valid_q || id_ready);

  fetch_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc            (pc_q),
    .load          (load),
    .is_ebreak     (is_ebreak),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .next_pc       (pc_d)
  );

  // Next-state and output-slot logic; a redirect flushes the slot and restarts fetch.
  always_comb begin
    state_d       = state_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      state_d    = FETCH;
      id_valid_d = 1'b0;
    end else if (load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = imem_data;
      id_pc_d       = pc_q;
      fetch_count_d = fetch_count_q + 32'd1;
      if (is_ebreak) begin
        state_d = HALTED;
      end
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, output slot and fetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q >> 2;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule
